proc_seq_ctrl: RTL

Sequencer for the image-processing datapath. It accepts a job from the slave register block: mode, processing value and word count. It then pulls pixel words from the input FIFO, applies the per-byte pixel operation, and pushes results to the output FIFO under back-pressure. When the last word is written it pulses `mstr_data_cmplt` toward the master.

---
 rtl/proc_seq_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/proc_seq_ctrl.sv
// proc_seq_ctrl: job sequencer that pulls pixel words from an input FIFO, applies a per-byte
// operation and pushes results to an output FIFO. Optional stall counter: PROC_STALL_CNT_EN.
module proc_seq_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  slv_start,
    input  logic [1:0]            slv_mode,
    input  logic [7:0]            slv_proc_val,
    input  logic [LEN_W-1:0]      slv_len,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  out_full,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  mstr_data_cmplt,
    output logic [15:0]           stall_cnt
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q;
    logic [7:0]            val_q;
    logic [LEN_W-1:0]      rd_left_q, wr_left_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            cnt_q;
    logic                  inflight_q;
    logic                  start_ok;
    logic                  pop_c;
    logic [2:0]            occ_c;
    logic [DATA_WIDTH-1:0] proc_word;

    // Per-pixel operation; 9-bit intermediates expose carry/borrow for clamping.
    function automatic logic [7:0] pixel_op(input logic [1:0] mode, input logic [7:0] p,
                                            input logic [7:0] v);
        logic [8:0] sum;
        logic [8:0] diff;
        sum  = {1'b0, p} + {1'b0, v};
        diff = {1'b0, p} - {1'b0, v};
        case (mode)
            2'b01:   return sum[8]  ? 8'hFF : sum[7:0];
            2'b10:   return diff[8] ? 8'h00 : diff[7:0];
            2'b11:   return diff[8] ? 8'h00 : 8'hFF;
            default: return p;
        endcase
    endfunction

    always_comb begin
        proc_word = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            proc_word[i*8 +: 8] = pixel_op(mode_q, fifo_data[i*8 +: 8], val_q);
        end
    end

    assign start_ok        = (state_q == S_IDLE) && slv_start;
    assign pop_c           = (cnt_q != 2'd0) && !out_full;
    // Issue accounting counts the same-cycle pop so a full buffer can still stream.
    assign occ_c           = 3'(cnt_q) + 3'(inflight_q) - 3'(pop_c);
    assign data_out        = buf_q[rd_ptr_q];
    assign busy            = (state_q != S_IDLE);
    assign mstr_data_cmplt = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        fifo_rd = 1'b0;
        wr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (slv_start) state_d = (slv_len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                fifo_rd = (rd_left_q != '0) && !fifo_empty && (occ_c < 3'd2);
                wr      = pop_c;
                if (pop_c && (wr_left_q == LEN_W'(1))) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Job config, word counters and the 2-entry result buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 2'b00;
            val_q      <= 8'h00;
            rd_left_q  <= '0;
            wr_left_q  <= '0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd;
            if (start_ok) begin
                mode_q    <= slv_mode;
                val_q     <= slv_proc_val;
                rd_left_q <= slv_len;
                wr_left_q <= slv_len;
            end else begin
                if (fifo_rd) rd_left_q <= rd_left_q - LEN_W'(1);
                if (wr)      wr_left_q <= wr_left_q - LEN_W'(1);
            end
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= proc_word;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (wr) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + 2'(inflight_q) - 2'(wr);
        end
    end

`ifdef PROC_STALL_CNT_EN
    logic [15:0] stall_q;

    // Counts RUN cycles where a result is waiting on a full output FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
        end else if (start_ok) begin
            stall_q <= 16'h0000;
        end else if ((state_q == S_RUN) && (cnt_q != 2'd0) && out_full &&
                     (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
